// File: rtl/mem_responder.sv
// Word-addressed memory responder servicing fetch/load/store requests with a req/ready handshake and WAIT_CYCLES wait states.
// Define MEM_RESP_ALIGN_CHECK_EN to reject accesses with addr[1:0]!=0 (err=1, no commit, rdata=0).
module mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_range;
    logic              aligned;
    logic              access_ok;
    logic              mem_we;
    logic [AW-1:0]     widx;

    assign in_range  = (addr_q[31:2] < 30'(DEPTH));
    assign widx      = addr_q[AW+1:2];
    assign access_ok = in_range & aligned;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign aligned = (addr_q[1:0] == 2'b00);
`else
    logic unused_byte_off;
    assign unused_byte_off = ^addr_q[1:0];
    assign aligned         = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // ready/err/rdata are registered here so they appear together in the following cycle
                ready_d = 1'b1;
                err_d   = ~access_ok;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (we_q) begin
                    mem_we = access_ok;
                end else begin
                    rdata_d = access_ok ? mem_q[widx] : '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage survives reset; a reset edge landing on RESP suppresses the commit.
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem_q[widx] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: unit 0 has two wait states, unit 1 has none; random traffic checked against an array model.
module tb_mem_responder;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int LIMIT = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        ready_s [2];
    logic        err_s   [2];
    logic        busy_s  [2];

    int checks = 0;
    int passes = 0;
    logic [31:0] model [64];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]), .busy(busy_s[0])
    );

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .DATA_W(32)) dut0 (
        .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]), .busy(busy_s[1])
    );

    // Issues one access from an idle cycle; lat counts edges after acceptance until ready is seen.
    task automatic access(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e,
                          output logic b0, output logic pulse_clean, output logic err_clean);
        req_s[u] = 1'b1; we_s[u] = w; addr_s[u] = a; wdata_s[u] = d;
        @(posedge clk); #1;
        req_s[u] = 1'b0; we_s[u] = 1'($urandom); addr_s[u] = $urandom; wdata_s[u] = $urandom;
        b0 = busy_s[u];
        lat = 0;
        err_clean = 1'b1;
        while (ready_s[u] !== 1'b1 && lat < LIMIT) begin
            if (err_s[u] !== 1'b0) err_clean = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_s[u];
        e  = err_s[u];
        @(posedge clk); #1;
        pulse_clean = (ready_s[u] === 1'b0) && (err_s[u] === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_s[u] = 1'b1; we_s[u] = 1'b1; addr_s[u] = 32'h0; wdata_s[u] = 32'hFFFF_FFFF;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (ready_s[0] !== 1'b0) $display("FAIL rst_ready cyc%0d got %b want 0", c, ready_s[0]); else passes++;
            checks++; if (busy_s[0] !== 1'b0) $display("FAIL rst_busy cyc%0d got %b want 0", c, busy_s[0]); else passes++;
            checks++; if (err_s[0] !== 1'b0) $display("FAIL rst_err cyc%0d got %b want 0", c, err_s[0]); else passes++;
            checks++; if (rdata_s[0] !== 32'h0) $display("FAIL rst_rdata cyc%0d got %h want 0", c, rdata_s[0]); else passes++;
        end
        checks++; if (busy_s[1] !== 1'b0 || ready_s[1] !== 1'b0) $display("FAIL rst_u1 got busy=%b ready=%b want 0/0", busy_s[1], ready_s[1]); else passes++;
        reset = 1'b1;
        req_s[0] = 1'b0; req_s[1] = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy_s[0] !== 1'b0) $display("FAIL rst_no_accept got busy=%b want 0", busy_s[0]); else passes++;
        last_rd = 32'h0;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic e, b0, pc, ec;
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e, b0, pc, ec);
        checks++; if (lat !== 3) $display("FAIL st_lat got %0d want 3", lat); else passes++;
        checks++; if (e !== 1'b0) $display("FAIL st_err got %b want 0", e); else passes++;
        checks++; if (b0 !== 1'b1) $display("FAIL st_busy got %b want 1", b0); else passes++;
        checks++; if (rd !== 32'h0) $display("FAIL st_rdata_hold got %h want 0", rd); else passes++;
        checks++; if (pc !== 1'b1 || ec !== 1'b1) $display("FAIL st_pulse got pulse_clean=%b err_clean=%b want 1/1", pc, ec); else passes++;
        access(0, 1'b0, 32'h10, 32'h0, lat, rd, e, b0, pc, ec);
        checks++; if (lat !== 3) $display("FAIL ld_lat got %0d want 3", lat); else passes++;
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_rdata got %h want deadbeef", rd); else passes++;
        checks++; if (e !== 1'b0) $display("FAIL ld_err got %b want 0", e); else passes++;
        access(0, 1'b1, 32'h14, 32'h11111111, lat, rd, e, b0, pc, ec);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL st2_rdata_hold got %h want deadbeef", rd); else passes++;
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_zero_wait();
        int lat; logic [31:0] rd; logic e, b0, pc, ec;
        access(1, 1'b1, 32'h0, 32'h20080005, lat, rd, e, b0, pc, ec);
        checks++; if (lat !== 1) $display("FAIL zw_st_lat got %0d want 1", lat); else passes++;
        access(1, 1'b0, 32'h0, 32'h0, lat, rd, e, b0, pc, ec);
        checks++; if (lat !== 1) $display("FAIL zw_ld_lat got %0d want 1", lat); else passes++;
        checks++; if (rd !== 32'h20080005) $display("FAIL zw_ld_rdata got %h want 20080005", rd); else passes++;
        checks++; if (b0 !== 1'b1 || pc !== 1'b1 || e !== 1'b0) $display("FAIL zw_flags got busy=%b pulse_clean=%b err=%b want 1/1/0", b0, pc, e); else passes++;
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic e, b0, pc, ec;
        access(0, 1'b1, 32'h0, 32'hCAFEF00D, lat, rd, e, b0, pc, ec);
        access(0, 1'b1, 32'h100, 32'h55555555, lat, rd, e, b0, pc, ec);
        checks++; if (e !== 1'b1 || lat !== 3) $display("FAIL oor_st got err=%b lat=%0d want 1/3", e, lat); else passes++;
        access(0, 1'b0, 32'h100, 32'h0, lat, rd, e, b0, pc, ec);
        checks++; if (e !== 1'b1 || lat !== 3) $display("FAIL oor_ld got err=%b lat=%0d want 1/3", e, lat); else passes++;
        checks++; if (rd !== 32'h0) $display("FAIL oor_ld_rdata got %h want 0", rd); else passes++;
        checks++; if (pc !== 1'b1 || ec !== 1'b1) $display("FAIL oor_err_only_with_ready got pulse_clean=%b err_clean=%b want 1/1", pc, ec); else passes++;
        access(0, 1'b0, 32'h0, 32'h0, lat, rd, e, b0, pc, ec);
        checks++; if (rd !== 32'hCAFEF00D || e !== 1'b0) $display("FAIL oor_word0 got %h err=%b want cafef00d/0", rd, e); else passes++;
        last_rd = 32'hCAFEF00D;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic e, b0, pc, ec;
        bit seen;
        access(0, 1'b1, 32'h8, 32'h0BADF00D, lat, rd, e, b0, pc, ec);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h8; wdata_s[0] = 32'h12345678;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (ready_s[0] === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL mid_rst_ready got seen=%b want 0", seen); else passes++;
        checks++; if (busy_s[0] !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy_s[0]); else passes++;
        access(0, 1'b0, 32'h8, 32'h0, lat, rd, e, b0, pc, ec);
        checks++; if (rd !== 32'h0BADF00D) $display("FAIL mid_rst_old got %h want 0badf00d", rd); else passes++;
        last_rd = 32'h0BADF00D;
    endtask

    task automatic test_align();
        int lat; logic [31:0] rd; logic e, b0, pc, ec;
        logic [31:0] exp_w;
        logic exp_e;
        access(0, 1'b1, 32'h4, 32'h44444444, lat, rd, e, b0, pc, ec);
        access(0, 1'b1, 32'h6, 32'hAAAA5555, lat, rd, e, b0, pc, ec);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        exp_e = 1'b1; exp_w = 32'h44444444;
`else
        exp_e = 1'b0; exp_w = 32'hAAAA5555;
`endif
        checks++; if (e !== exp_e || lat !== 3) $display("FAIL al_st got err=%b lat=%0d want %b/3", e, lat, exp_e); else passes++;
        access(0, 1'b0, 32'h4, 32'h0, lat, rd, e, b0, pc, ec);
        checks++; if (rd !== exp_w) $display("FAIL al_word4 got %h want %h", rd, exp_w); else passes++;
        access(0, 1'b0, 32'h5, 32'h0, lat, rd, e, b0, pc, ec);
        checks++; if (e !== exp_e || rd !== (exp_e ? 32'h0 : exp_w)) $display("FAIL al_ld got %h err=%b want %h/%b", rd, e, exp_e ? 32'h0 : exp_w, exp_e); else passes++;
        last_rd = rd;
    endtask

    // req stays high across the first completion, so the second access is taken in the ready cycle.
    task automatic test_back_to_back();
        int gap, t0;
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h10; wdata_s[0] = 32'h0;
        @(posedge clk); #1;
        t0 = 0;
        while (ready_s[0] !== 1'b1 && t0 < LIMIT) begin
            @(posedge clk); #1;
            t0++;
        end
        checks++; if (t0 !== 3 || rdata_s[0] !== 32'hDEADBEEF) $display("FAIL b2b_first got lat=%0d rdata=%h want 3/deadbeef", t0, rdata_s[0]); else passes++;
        addr_s[0] = 32'h14;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        gap = 1;
        while (ready_s[0] !== 1'b1 && gap < LIMIT) begin
            @(posedge clk); #1;
            gap++;
        end
        checks++; if (gap !== 4 || rdata_s[0] !== 32'h11111111) $display("FAIL b2b_second got gap=%0d rdata=%h want 4/11111111", gap, rdata_s[0]); else passes++;
        @(posedge clk); #1;
        checks++; if (busy_s[0] !== 1'b0 || ready_s[0] !== 1'b0) $display("FAIL b2b_no_third got busy=%b ready=%b want 0/0", busy_s[0], ready_s[0]); else passes++;
        last_rd = 32'h11111111;
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic e, b0, pc, ec;
        int word, off;
        bit w, oob, exp_e;
        logic [31:0] d, exp_rd;
        for (int i = 0; i < 64; i++) begin
            model[i] = $urandom;
            access(0, 1'b1, 32'(i * 4), model[i], lat, rd, e, b0, pc, ec);
            checks++; if (lat !== 3 || e !== 1'b0) $display("FAIL fill%0d got lat=%0d err=%b want 3/0", i, lat, e); else passes++;
        end
        for (int i = 0; i < 60; i++) begin
            word = $urandom_range(0, 71);
            off  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            w    = 1'($urandom);
            d    = $urandom;
            oob  = (word >= 64);
            exp_e = oob || (ALIGN && off != 0);
            if (w) begin
                exp_rd = last_rd;
                if (!exp_e) model[word] = d;
            end else begin
                exp_rd = exp_e ? 32'h0 : model[word];
                last_rd = exp_rd;
            end
            access(0, w, 32'(word * 4 + off), d, lat, rd, e, b0, pc, ec);
            checks++; if (lat !== 3) $display("FAIL rnd%0d_lat got %0d want 3", i, lat); else passes++;
            checks++; if (e !== exp_e) $display("FAIL rnd%0d_err addr=%h we=%b got %b want %b", i, word * 4 + off, w, e, exp_e); else passes++;
            checks++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata addr=%h we=%b got %h want %h", i, word * 4 + off, w, rd, exp_rd); else passes++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_zero_wait();
        test_out_of_range();
        test_reset_mid();
        test_align();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
